// File: rtl/flit_sink.sv
`default_nettype none
// ============================================================================
// Module   : flit_sink
// Purpose  : Ejection-side flit consumer. Reassembles packets per VC, checks
//            head/body/tail sequencing and head destination, counts completed
//            packets and raises done once the expected count has arrived.
//            Optional macro SINK_CREDIT_EN adds a one-hot per-VC credit return.
// Revision : 1.0 - initial release
// ============================================================================
module flit_sink #(
  parameter int                 FLIT_W  = 32,
  parameter int                 DEST_W  = 14,
  parameter int                 NUM_VC  = 4,
  parameter int                 VC_W    = 2,
  parameter logic [DEST_W-1:0]  NODE_ID = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op,
  input  logic [31:0]       data,
  input  logic              flit_valid,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic [VC_W-1:0]   flit_vc,
  output logic              flit_ready,
  output logic [9:0]        pkts_rcvd,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [NUM_VC-1:0] credit_out
);

  localparam logic [2:0] OP_INIT      = 3'd5;
  localparam logic [9:0] PKT_MAX      = 10'd1023;
  localparam logic [1:0] ERR_ORPHAN   = 2'd1;
  localparam logic [1:0] ERR_NESTED   = 2'd2;
  localparam logic [1:0] ERR_DEST     = 2'd3;

  typedef enum logic [0:0] {
    VC_IDLE   = 1'b0,
    VC_IN_PKT = 1'b1
  } vc_state_e;

  vc_state_e   vc_state_q [NUM_VC];
  vc_state_e   vc_state_d [NUM_VC];
  logic [9:0]  pkts_q, pkts_d;
  logic [9:0]  expected_q, expected_d;
  logic        armed_q, armed_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        is_init;
  logic        accept;
  logic        is_head;
  logic        is_tail;
  logic        dest_ok;
  logic [1:0]  flit_err;
  logic        count_pkt;

  assign is_init = (op == OP_INIT);
  // A flit arriving in an Init cycle is deliberately not accepted.
  assign accept  = flit_valid && !is_init;
  assign is_head = flit_in[FLIT_W-1];
  assign is_tail = flit_in[FLIT_W-2];
  assign dest_ok = (flit_in[DEST_W-1:0] == NODE_ID);

  // Per-VC reassembly, error capture and packet counting.
  always_comb begin
    vc_state_d = vc_state_q;
    pkts_d     = pkts_q;
    expected_d = expected_q;
    armed_d    = armed_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    flit_err   = 2'd0;
    count_pkt  = 1'b0;

    if (is_init) begin
      pkts_d     = '0;
      expected_d = data[31:22];
      armed_d    = 1'b1;
      err_d      = 1'b0;
      err_code_d = '0;
      for (int i = 0; i < NUM_VC; i++) vc_state_d[i] = VC_IDLE;
    end else if (accept) begin
      if (is_head) begin
        // Nested head outranks a dest mismatch on the same flit (lower code).
        if (vc_state_q[flit_vc] == VC_IN_PKT) flit_err = ERR_NESTED;
        else if (!dest_ok)                    flit_err = ERR_DEST;
        // The open packet (if any) is dropped; the new head starts afresh.
        if (is_tail) begin
          count_pkt            = 1'b1;
          vc_state_d[flit_vc]  = VC_IDLE;
        end else begin
          vc_state_d[flit_vc]  = VC_IN_PKT;
        end
      end else if (vc_state_q[flit_vc] == VC_IDLE) begin
        flit_err = ERR_ORPHAN;
      end else if (is_tail) begin
        count_pkt           = 1'b1;
        vc_state_d[flit_vc] = VC_IDLE;
      end

      if (count_pkt && (pkts_q != PKT_MAX)) pkts_d = pkts_q + 10'd1;

      // Only the first error since Init/reset is recorded.
      if ((flit_err != 2'd0) && !err_q) begin
        err_d      = 1'b1;
        err_code_d = flit_err;
      end
    end
  end

  // State registers with synchronous reset; reset abandons open packets silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VC; i++) vc_state_q[i] <= VC_IDLE;
      pkts_q     <= '0;
      expected_q <= '0;
      armed_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      vc_state_q <= vc_state_d;
      pkts_q     <= pkts_d;
      expected_q <= expected_d;
      armed_q    <= armed_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign flit_ready = !rst && !is_init;
  assign pkts_rcvd  = pkts_q;
  assign done       = armed_q && (pkts_q >= expected_q);
  assign err        = err_q;
  assign err_code   = err_code_q;

`ifdef SINK_CREDIT_EN
  logic [NUM_VC-1:0] credit_q, credit_d;

  // One credit per accepted flit, returned on its VC the following cycle.
  always_comb begin
    credit_d = '0;
    if (accept) credit_d[flit_vc] = 1'b1;
  end

  // Credit pulse register; reset discards any in-flight credit.
  always_ff @(posedge clk) begin
    if (rst) credit_q <= '0;
    else     credit_q <= credit_d;
  end

  assign credit_out = credit_q;
`else
  assign credit_out = '0;
`endif

  // Payload bits and the low data bits carry nothing this block uses.
  logic unused_bits;
  assign unused_bits = ^{data[21:0], flit_in[FLIT_W-3:DEST_W]};

endmodule
`default_nettype wire

// File: tb/tb_flit_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_flit_sink
// Purpose  : Directed, table-driven bench for flit_sink (NODE_ID = 0).
//            Credit checks follow SINK_CREDIT_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flit_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [31:0] data;
  logic        flit_valid;
  logic [31:0] flit_in;
  logic [1:0]  flit_vc;
  logic        flit_ready;
  logic [9:0]  pkts_rcvd;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [3:0]  credit_out;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  flit_sink dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .data       (data),
    .flit_valid (flit_valid),
    .flit_in    (flit_in),
    .flit_vc    (flit_vc),
    .flit_ready (flit_ready),
    .pkts_rcvd  (pkts_rcvd),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .credit_out (credit_out)
  );

  typedef struct {
    logic [2:0]  op;
    logic [9:0]  cnt;
    logic        valid;
    logic        h;
    logic        t;
    logic [13:0] dest;
    logic [1:0]  vc;
    logic [9:0]  e_pkts;
    logic        e_done;
    logic        e_err;
    logic [1:0]  e_code;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] op_i, input logic [9:0] cnt_i,
                              input logic v_i, input logic h_i, input logic t_i,
                              input logic [13:0] dest_i, input logic [1:0] vc_i,
                              input logic [9:0] pk, input logic dn,
                              input logic er, input logic [1:0] cd);
    vec_t r;
    r.op = op_i; r.cnt = cnt_i; r.valid = v_i; r.h = h_i; r.t = t_i;
    r.dest = dest_i; r.vc = vc_i; r.e_pkts = pk; r.e_done = dn;
    r.e_err = er; r.e_code = cd;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic drive_idle();
    op = 3'd0; data = '0; flit_valid = 1'b0; flit_in = '0; flit_vc = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [3:0] exp_cr;
    @(negedge clk);
    op         = v.op;
    data       = {v.cnt, 22'h0};
    flit_valid = v.valid;
    flit_in    = {v.h, v.t, 16'h0, v.dest};
    flit_vc    = v.vc;
    #1;
    check($sformatf("v%0d flit_ready", idx), {31'b0, flit_ready}, {31'b0, (v.op != 3'd5)});
    exp_cr = 4'b0;
`ifdef SINK_CREDIT_EN
    if (v.valid && v.op != 3'd5) exp_cr = 4'b0001 << v.vc;
`endif
    @(posedge clk); #1;
    check($sformatf("v%0d pkts_rcvd", idx),  {22'b0, pkts_rcvd}, {22'b0, v.e_pkts});
    check($sformatf("v%0d done", idx),       {31'b0, done},      {31'b0, v.e_done});
    check($sformatf("v%0d err", idx),        {31'b0, err},       {31'b0, v.e_err});
    check($sformatf("v%0d err_code", idx),   {30'b0, err_code},  {30'b0, v.e_code});
    check($sformatf("v%0d credit_out", idx), {28'b0, credit_out}, {28'b0, exp_cr});
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    vecs.delete();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst flit_ready", {31'b0, flit_ready}, 32'd0);
    check("rst pkts_rcvd",  {22'b0, pkts_rcvd},  32'd0);
    check("rst done",       {31'b0, done},       32'd0);
    check("rst err",        {31'b0, err},        32'd0);
    check("rst err_code",   {30'b0, err_code},   32'd0);
    check("rst credit_out", {28'b0, credit_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two packets on VC0 (H,B,T) and VC1 (H+T)
    vecs.push_back(mk(5, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1,  2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1,  2, 1, 0, 0));
    // Interleaved VC2/VC3, then both reused as idle; op=3 is ignored
    vecs.push_back(mk(5, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 2,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 3,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 2,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 3,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 3,  2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 2,  3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 3,  4, 1, 0, 0));
    vecs.push_back(mk(3, 0, 1, 1, 1, 0, 2,  5, 1, 0, 0));
    // Orphan body, then wrong-dest head keeps code 1 and still counts
    vecs.push_back(mk(5, 5, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 5, 1,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1,  1, 0, 1, 1));
    // Nested head drops the open packet
    vecs.push_back(mk(5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0,  1, 1, 1, 2));
    // Dest mismatch alone
    vecs.push_back(mk(5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 3, 0,  0, 0, 1, 3));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0,  1, 1, 1, 3));
    // Nested head with wrong dest records the lower code
    vecs.push_back(mk(5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 3, 0,  0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0,  1, 1, 1, 2));
    // Nested single-flit head on an open VC still counts
    vecs.push_back(mk(5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1,  1, 1, 1, 2));
    // Orphan tail, later errors do not overwrite
    vecs.push_back(mk(5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 3,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 7, 3,  1, 1, 1, 1));
    // expected = 0 gives done right after Init
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0));
    // Head presented during Init is dropped, so the tail is an orphan
    vecs.push_back(mk(5, 3, 1, 1, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0,  0, 0, 1, 1));
    // Open a packet ahead of a mid-packet reset
    vecs.push_back(mk(5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1,  0, 0, 0, 0));
    run_table();

    // Mid-packet reset: a flit during reset is dropped and the VC returns to idle
    @(negedge clk);
    rst = 1'b1; flit_valid = 1'b1; flit_in = {2'b01, 30'h0}; flit_vc = 2'd1;
    #1;
    check("midrst flit_ready", {31'b0, flit_ready}, 32'd0);
    @(posedge clk); #1;
    check("midrst pkts_rcvd", {22'b0, pkts_rcvd}, 32'd0);
    check("midrst err",       {31'b0, err},       32'd0);
    check("midrst done",      {31'b0, done},      32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    check("midrst credit_out", {28'b0, credit_out}, 32'd0);
    // Tail after reset (no Init) is an orphan; done stays low while unarmed
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1,  0, 0, 1, 1));
    run_table();

    // Saturation: 1100 single-flit packets
    vecs.push_back(mk(5, 10'd1023, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    run_table();
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      op = 3'd0; flit_valid = 1'b1; flit_in = {2'b11, 30'h0}; flit_vc = 2'(k % 4);
    end
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    check("sat pkts_rcvd", {22'b0, pkts_rcvd}, 32'd1023);
    check("sat done",      {31'b0, done},      32'd1);
    check("sat err",       {31'b0, err},       32'd0);

`ifdef SINK_CREDIT_EN
    // Three back-to-back flits on VC2, each credited one cycle later
    vecs.push_back(mk(5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    run_table();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      flit_valid = 1'b1; flit_vc = 2'd2;
      flit_in = (k == 0) ? {2'b10, 30'h0} : (k == 1) ? 32'h0 : {2'b01, 30'h0};
      #1;
      check($sformatf("cr%0d pre", k), {28'b0, credit_out}, (k == 0) ? 32'd0 : 32'd4);
      @(posedge clk); #1;
      check($sformatf("cr%0d post", k), {28'b0, credit_out}, 32'd4);
    end
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    check("cr idle", {28'b0, credit_out}, 32'd0);
    check("cr pkts", {22'b0, pkts_rcvd},  32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
